// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO for GCD operand words: configurable width/depth,
// almost-full/empty thresholds, optional first-word-fall-through and sticky error flags.
module param_sync_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_CNT  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_CNT = AEMPTY_TH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // RAM is not reset; writes are suppressed during the reset cycle.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else if (rd_acc) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: registered-read and FWFT instances share stimulus and are
// compared against a queue-based reference model of the FIFO behaviour.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic        clr_err;

  logic [15:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic [3:0]  count0, count1;
  logic        full0, full1, empty0, empty1;
  logic        af0, af1, ae0, ae1;
  logic        ovf0, ovf1, unf0, unf1;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] q[$];
  logic        m_ovf, m_unf, m_rdv;
  logic [15:0] m_rdd;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(16), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) d0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err));

  param_sync_fifo #(.DATA_W(16), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) d1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err));

  // Drive one cycle of requests, advance the model at the edge, return 1 time unit later.
  task automatic cycle(input logic we, input logic [15:0] wd, input logic re,
                       input logic ce, input logic rst);
    logic ra, wa;
    reset = rst; wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = 16'h0000;
    end else begin
      ra = re && (q.size() > 0);
      wa = we && ((q.size() < 8) || ra);
      if (we && !wa) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (re && !ra) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
      m_rdv = ra;
      if (ra) m_rdd = q.pop_front();
      if (wa) q.push_back(wd);
    end
    #1;
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset;
    cycle(0, 16'h0, 0, 0, 1);
    checks++; if (count0 !== 4'd0 || count1 !== 4'd0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0", count0, count1); end
    checks++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b exp 1010", {empty0, full0, ae0, af0}); end
    checks++; if ({rd_valid0, rd_valid1, ovf0, unf0} !== 4'b0000) begin errors++; $display("FAIL reset_valid_err got %b exp 0000", {rd_valid0, rd_valid1, ovf0, unf0}); end
    checks++; if (rd_data0 !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data0); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 16'(i), 0, 0, 0);
      checks++; if (count0 !== 4'(i) || count1 !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d/%0d exp %0d", count0, count1, i); end
      checks++; if (af0 !== (i >= 6) || full0 !== (i == 8) || ae0 !== (i <= 2)) begin errors++; $display("FAIL fill_flags i=%0d got af=%b full=%b ae=%b", i, af0, full0, ae0); end
      checks++; if (ovf0 !== 1'b0 || empty0 !== 1'b0) begin errors++; $display("FAIL fill_ovf_empty got %b%b exp 00", ovf0, empty0); end
    end
    checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h0001) begin errors++; $display("FAIL fill_fwft_head got %b %h exp 1 0001", rd_valid1, rd_data1); end
  endtask

  task automatic test_overflow;
    cycle(1, 16'hBEEF, 0, 0, 0);
    checks++; if (count0 !== 4'd8 || full0 !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d full=%b exp 8 1", count0, full0); end
    checks++; if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_set got %b/%b exp 1", ovf0, ovf1); end
    cycle(0, 16'h0, 0, 1, 0);
    checks++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b/%b exp 0", ovf0, ovf1); end
    // set and clear together: set wins
    cycle(1, 16'hBEEF, 0, 1, 0);
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf0); end
    cycle(0, 16'h0, 0, 1, 0);
  endtask

  task automatic test_full_rw;
    logic [15:0] exp;
    cycle(1, 16'h0100, 1, 0, 0);
    checks++; if (count0 !== 4'd8 || ovf0 !== 1'b0) begin errors++; $display("FAIL full_rw_count got %0d ovf=%b exp 8 0", count0, ovf0); end
    checks++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h0001) begin errors++; $display("FAIL full_rw_data got %b %h exp 1 0001", rd_valid0, rd_data0); end
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? 16'(k + 2) : 16'h0100;
      checks++; if (rd_data1 !== exp) begin errors++; $display("FAIL drain_fwft k=%0d got %h exp %h", k, rd_data1, exp); end
      cycle(0, 16'h0, 1, 0, 0);
      checks++; if (rd_valid0 !== 1'b1 || rd_data0 !== exp) begin errors++; $display("FAIL drain k=%0d got %b %h exp 1 %h", k, rd_valid0, rd_data0, exp); end
    end
    checks++; if (empty0 !== 1'b1 || rd_valid1 !== 1'b0 || unf0 !== 1'b0) begin errors++; $display("FAIL drain_end got e=%b v=%b u=%b", empty0, rd_valid1, unf0); end
    cycle(0, 16'h0, 0, 0, 0);
    checks++; if (rd_valid0 !== 1'b0 || rd_data0 !== 16'h0100) begin errors++; $display("FAIL rd_hold got %b %h exp 0 0100", rd_valid0, rd_data0); end
  endtask

  task automatic test_empty_rw;
    cycle(1, 16'h0055, 1, 0, 0);
    checks++; if (count0 !== 4'd1 || unf0 !== 1'b1 || unf1 !== 1'b1) begin errors++; $display("FAIL empty_rw got cnt=%0d unf=%b/%b exp 1 1", count0, unf0, unf1); end
    checks++; if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL empty_rw_valid got %b exp 0", rd_valid0); end
    checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h0055) begin errors++; $display("FAIL empty_rw_fwft got %b %h exp 1 0055", rd_valid1, rd_data1); end
    cycle(0, 16'h0, 1, 1, 0);
    checks++; if (unf0 !== 1'b0 || empty0 !== 1'b1 || rd_data0 !== 16'h0055) begin errors++; $display("FAIL empty_rw_pop got u=%b e=%b d=%h", unf0, empty0, rd_data0); end
  endtask

  task automatic test_fwft;
    cycle(1, 16'h1234, 0, 0, 0);
    checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h1234 || count1 !== 4'd1) begin errors++; $display("FAIL fwft_show got %b %h cnt=%0d exp 1 1234 1", rd_valid1, rd_data1, count1); end
    cycle(0, 16'h0, 1, 0, 0);
    checks++; if (rd_valid1 !== 1'b0 || empty1 !== 1'b1) begin errors++; $display("FAIL fwft_pop got v=%b e=%b exp 0 1", rd_valid1, empty1); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) cycle(1, 16'(16'hA0 + i), 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    checks++; if (unf0 !== 1'b1) begin errors++; $display("FAIL mid_unf_pre got %b exp 1", unf0); end
    for (int i = 0; i < 5; i++) cycle(1, 16'(16'hB0 + i), 0, 0, 0);
    checks++; if (count0 !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", count0); end
    cycle(1, 16'hDEAD, 1, 0, 1);
    checks++; if (count0 !== 4'd0 || count1 !== 4'd0 || empty0 !== 1'b1) begin errors++; $display("FAIL mid_reset_count got %0d/%0d e=%b", count0, count1, empty0); end
    checks++; if ({rd_valid0, rd_valid1, ovf0, unf0, ovf1, unf1} !== 6'b0) begin errors++; $display("FAIL mid_reset_flags got %b exp 000000", {rd_valid0, rd_valid1, ovf0, unf0, ovf1, unf1}); end
  endtask

  task automatic test_random;
    logic we, re, ce;
    int   wp;
    for (int n = 0; n < 600; n++) begin
      wp = ((n / 50) % 2 == 0) ? 80 : 25;
      we = ($urandom_range(99) < wp);
      re = ($urandom_range(99) < (105 - wp));
      ce = ($urandom_range(99) < 8);
      cycle(we, 16'($urandom), re, ce, ($urandom_range(999) < 3));
      checks++; if (count0 !== 4'(q.size()) || count1 !== 4'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d got %0d/%0d exp %0d", n, count0, count1, q.size()); end
      checks++; if ({full0, empty0, af0, ae0} !== {q.size() == 8, q.size() == 0, q.size() >= 6, q.size() <= 2}) begin errors++; $display("FAIL rnd_flags n=%0d got %b cnt=%0d", n, {full0, empty0, af0, ae0}, q.size()); end
      checks++; if ({ovf0, unf0, ovf1, unf1} !== {m_ovf, m_unf, m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b%b", n, {ovf0, unf0, ovf1, unf1}, m_ovf, m_unf); end
      checks++; if (rd_valid0 !== m_rdv || rd_data0 !== m_rdd) begin errors++; $display("FAIL rnd_rd n=%0d got %b %h exp %b %h", n, rd_valid0, rd_data0, m_rdv, m_rdd); end
      checks++; if (rd_valid1 !== (q.size() > 0) || (q.size() > 0 && rd_data1 !== q[0])) begin errors++; $display("FAIL rnd_fwft n=%0d got %b %h", n, rd_valid1, rd_data1); end
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = 16'h0;
    test_reset;
    test_fill;
    test_overflow;
    test_full_rw;
    test_empty_rw;
    test_fwft;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO buffering operand words between the GCD calculator's input interface and its datapath. It generalises the team's fixed 8-entry FIFO with configurable width and depth and a correctly sized occupancy count. It adds a defined full/empty simultaneous-access policy, almost-full/almost-empty thresholds, an optional first-word-fall-through read mode, and sticky overflow/underflow error flags.

## Interface
- DATA_W, 16, data word width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (8 by default)
- AFULL_TH, 6, almost_full asserted when count >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- wr_en  input  1  write request
- wr_data  input  DATA_W  write data
- rd_en  input  1  read (pop) request
- rd_data  output  DATA_W  read data
- rd_valid  output  1  rd_data qualifier
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- full / empty  output  1 each  count==DEPTH / count==0
- almost_full / almost_empty  output  1 each  threshold flags
- overflow / underflow  output  1 each  sticky error flags
- clr_err  input  1  clears overflow and underflow

## Operation
- Storage is DEPTH x DATA_W RAM with ADDR_W-bit rd_ptr/wr_ptr that wrap naturally from DEPTH-1 to 0.
- Read accepted (rd_acc) = rd_en && !empty.
- Write accepted (wr_acc) = wr_en && (!full || rd_acc). When full, a simultaneous read frees a slot and both are accepted. When empty, a simultaneous read is rejected and the write is accepted.
- wr_acc: mem[wr_ptr] <= wr_data, wr_ptr++. rd_acc: rd_ptr++.
- count: +1 if wr_acc only, -1 if rd_acc only, unchanged if both or neither. It never leaves 0..DEPTH.
- full, empty, almost_full and almost_empty decode combinationally from count.
- overflow is set when wr_en && !wr_acc. underflow is set when rd_en && !rd_acc. Both hold until reset or clr_err. If a set condition and clr_err occur in the same cycle, the flag ends set.
- FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 for the next cycle only. Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1: rd_data = mem[rd_ptr] combinationally and rd_valid = !empty. rd_en acknowledges (pops) the shown word.
- Reset: rd_ptr, wr_ptr, count, rd_data, rd_valid, overflow and underflow all go to 0. Hence empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0 ? 1 : 0). RAM contents are not reset.
- Reset mid-operation discards all stored data. Requests in the reset cycle are ignored and raise no error flags.

## Timing
- Write-to-read latency: a word written at edge N is visible to a read at edge N+1.
  - FWFT=1 with empty FIFO: rd_valid rises after edge N (same cycle count becomes 1).
  - FWFT=0: rd_data/rd_valid appear one cycle after the accepting rd_en edge.
- All flags and count update at the same edge as the accepted operation. There is no extra pipeline delay.
- Throughput is one write and one read per cycle sustained, including at full and at empty+write.
- Error flags are set at the edge following the rejected request.

## Test plan
- Reset, then write 8 words 0x0001..0x0008 -> count 1..8; almost_full at count=6; full=1 at 8; no overflow.
- Full FIFO, wr_en=1 (0xBEEF) alone -> write dropped, count stays 8, overflow=1 next cycle. clr_err pulse -> overflow=0.
- Full FIFO, wr_en and rd_en together -> both accepted; count stays 8; read returns oldest word. After draining, order matches writes with pointer wraparound verified.
- Empty FIFO, wr_en and rd_en together -> write accepted, read rejected; count=1; underflow=1; (FWFT=0) rd_valid stays 0.
- FWFT=1: write 0x1234 into empty FIFO -> next cycle rd_valid=1, rd_data=0x1234. rd_en -> empty=1, rd_valid=0 next cycle.
- Reset asserted with count=5 and wr_en=1 -> next cycle count=0, empty=1, rd_valid=0, overflow=underflow=0.
